rs_issue_sched: RTL

RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

---
 rtl/rs_issue_sched_pkg.sv | 11 +
 rtl/rs_issue_sched_age_oldest_sel.sv | 23 ++
 rtl/rs_issue_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/rs_issue_sched_pkg.sv
// Shared types for the reservation-station issue scheduler.
package rs_issue_sched_pkg;
  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_MUL = 2'd1,
    CLS_MEM = 2'd2,
    CLS_BR  = 2'd3
  } cls_e;

  localparam int N_ENT_DEF = 12;
endpackage

// File: rtl/rs_issue_sched_age_oldest_sel.sv
// Age-matrix oldest picker: grants the one requester that no other requester predates.
module age_oldest_sel
  import rs_issue_sched_pkg::*;
#(
  parameter int N = N_ENT_DEF
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0]        grant
);
  for (genvar i = 0; i < N; i++) begin : g_ent
    logic [N-1:0] col;
    // column i: which entries are older than i (diagonal masked against stale bits)
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == i) begin : g_diag
        assign col[j] = 1'b0;
      end else begin : g_off
        assign col[j] = older[j][i];
      end
    end
    assign grant[i] = req[i] & ~|(req & col);
  end
endmodule

// File: rtl/rs_issue_sched.sv
// Single-issue reservation-station scheduler: oldest-ready select with MUL occupancy and in-order MEM.
module rs_issue_sched
  import rs_issue_sched_pkg::*;
#(
  parameter int N_ENT   = N_ENT_DEF,
  parameter int MUL_LAT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [$clog2(N_ENT)-1:0] alloc_idx,
  input  logic [1:0]               alloc_class,
  input  logic [N_ENT-1:0]         ready_vec,
  input  logic                     ex_stall,
  output logic                     issue_valid,
  output logic [$clog2(N_ENT)-1:0] issue_idx,
  output logic [N_ENT-1:0]         issue_onehot,
  output logic [1:0]               issue_class,
  output logic                     mul_busy,
  output logic                     alloc_err
);
  localparam int IW = $clog2(N_ENT);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [N_ENT-1:0]            valid;
  cls_e [N_ENT-1:0]            cls;
  logic [N_ENT-1:0][N_ENT-1:0] older;
  logic [CW-1:0]               mul_cnt;

  logic [N_ENT-1:0] is_mem, mem_head, gate, elig, sel;
  logic [N_ENT-1:0] alloc_dec, alloc_ok, iss_mask, keep;
  logic             do_issue, alloc_dup;
  logic [IW-1:0]    sel_idx;
  cls_e             sel_cls;

  for (genvar g = 0; g < N_ENT; g++) begin : g_ent
    assign is_mem[g]    = valid[g] & (cls[g] == CLS_MEM);
    assign alloc_dec[g] = alloc_valid & (alloc_idx == IW'(g));
    always_comb begin
      unique case (cls[g])
        CLS_MUL: gate[g] = (mul_cnt == '0);
        CLS_MEM: gate[g] = mem_head[g];
        default: gate[g] = 1'b1;
      endcase
    end
  end

  // Oldest valid MEM entry is the only MEM allowed to go, keeping MEM in program order.
  age_oldest_sel #(.N(N_ENT)) u_mem_head (.req(is_mem), .older(older), .grant(mem_head));

  assign elig = valid & ready_vec & gate;

  age_oldest_sel #(.N(N_ENT)) u_issue_sel (.req(elig), .older(older), .grant(sel));

  always_comb begin
    sel_idx = '0;
    sel_cls = CLS_ALU;
    for (int i = 0; i < N_ENT; i++) begin
      if (sel[i]) begin
        sel_idx = IW'(i);
        sel_cls = cls[i];
      end
    end
  end

  assign do_issue  = ~ex_stall & (|sel);
  assign iss_mask  = do_issue ? sel : '0;
  assign keep      = valid & ~iss_mask;
  // Alloc onto a tracked entry (even one leaving this cycle) is refused.
  assign alloc_ok  = alloc_dec & ~valid;
  assign alloc_dup = |(alloc_dec & valid);
  assign mul_busy  = (mul_cnt != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid        <= '0;
      cls          <= '0;
      older        <= '0;
      mul_cnt      <= '0;
      issue_valid  <= 1'b0;
      issue_idx    <= '0;
      issue_onehot <= '0;
      issue_class  <= '0;
      alloc_err    <= 1'b0;
    end else if (flush) begin
      valid        <= '0;
      mul_cnt      <= '0;
      issue_valid  <= 1'b0;
      issue_onehot <= '0;
    end else begin
      valid <= keep | alloc_ok;
      if (do_issue) begin
        issue_valid  <= 1'b1;
        issue_idx    <= sel_idx;
        issue_onehot <= sel;
        issue_class  <= sel_cls;
      end else if (!ex_stall) begin
        issue_valid  <= 1'b0;
        issue_onehot <= '0;
      end
      if (do_issue && sel_cls == CLS_MUL) mul_cnt <= CW'(MUL_LAT - 1);
      else if (mul_cnt != '0)             mul_cnt <= mul_cnt - CW'(1);
      if (alloc_dup) alloc_err <= 1'b1;
      for (int i = 0; i < N_ENT; i++) begin
        if (alloc_ok[i]) begin
          cls[i]   <= cls_e'(alloc_class);
          older[i] <= '0;
          for (int j = 0; j < N_ENT; j++) older[j][i] <= keep[j];
        end
      end
    end
  end
endmodule
